// File: rtl/encap_link_arbiter.sv
// Round-robin arbiter that shares one Aurora TX lane between N_PORTS encapsulators.
// Define ENCAP_ARB_STATS_EN to add the msg_count/timeout_count statistics outputs.
module encap_link_arbiter #(
    parameter int N_PORTS           = 4,
    parameter int NUMBER_PACKET     = 19,
    parameter int PKT_CNT_WIDTH     = $clog2(NUMBER_PACKET),
    parameter int AURORA_DATA_WIDTH = 64,
    parameter int PORT_ID_WIDTH     = $clog2(N_PORTS),
    parameter int TIMEOUT_CYCLES    = 256
) (
    input  logic                                 clk,
    input  logic                                 rst_n,
    input  logic [N_PORTS-1:0]                   req,
    output logic [N_PORTS-1:0]                   gnt,
    input  logic [N_PORTS*AURORA_DATA_WIDTH-1:0] data_in,
    input  logic [N_PORTS-1:0]                   valid_in,
    input  logic                                 link_ready,
    output logic [AURORA_DATA_WIDTH-1:0]         tx_tdata,
    output logic                                 tx_tvalid,
    output logic                                 tx_tlast,
    output logic                                 busy,
    output logic [PORT_ID_WIDTH-1:0]             cur_port,
    output logic                                 msg_done,
    output logic                                 timeout_err
`ifdef ENCAP_ARB_STATS_EN
    ,
    output logic [15:0]                          msg_count,
    output logic [7:0]                           timeout_count
`endif
);
    // state    | meaning
    // S_IDLE   | lane free, arbitrate among requesters when link is up
    // S_GRANT  | one-cycle start grant to the winner; a beat may already arrive
    // S_STREAM | forward the owner's beats, watchdog counts silent cycles
    // S_GAP    | one forced idle lane cycle before the next arbitration
    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_GRANT  = 2'd1;
    localparam logic [1:0] S_STREAM = 2'd2;
    localparam logic [1:0] S_GAP    = 2'd3;

    localparam int IDLE_CNT_WIDTH = $clog2(TIMEOUT_CYCLES);

    logic [1:0]                   r_state;
    logic [PORT_ID_WIDTH-1:0]     r_rr_ptr;
    logic [PORT_ID_WIDTH-1:0]     r_cur_port;
    logic [PKT_CNT_WIDTH-1:0]     r_beat_cnt;
    logic [IDLE_CNT_WIDTH-1:0]    r_idle_cnt;
    logic [N_PORTS-1:0]           r_gnt;
    logic [AURORA_DATA_WIDTH-1:0] r_tdata;
    logic                         r_tvalid;
    logic                         r_tlast;
    logic                         r_msg_done;
    logic                         r_timeout;

    logic                         w_found;
    logic [PORT_ID_WIDTH-1:0]     w_winner;
    logic [PORT_ID_WIDTH-1:0]     w_scan_idx;
    logic [PORT_ID_WIDTH-1:0]     w_next_ptr;
    logic                         w_valid;
    logic [AURORA_DATA_WIDTH-1:0] w_data;
    logic                         w_last_beat;
    logic                         w_idle_expired;

    // Scan downward so the requester closest to r_rr_ptr is written last and wins.
    always_comb begin
        w_found    = 1'b0;
        w_winner   = '0;
        w_scan_idx = '0;
        for (int k = N_PORTS - 1; k >= 0; k--) begin
            w_scan_idx = PORT_ID_WIDTH'((int'(r_rr_ptr) + k) % N_PORTS);
            if (req[w_scan_idx]) begin
                w_found  = 1'b1;
                w_winner = w_scan_idx;
            end
        end
    end

    assign w_valid        = valid_in[r_cur_port];
    assign w_data         = data_in[int'(r_cur_port) * AURORA_DATA_WIDTH +: AURORA_DATA_WIDTH];
    assign w_last_beat    = (r_beat_cnt == PKT_CNT_WIDTH'(NUMBER_PACKET - 1));
    assign w_idle_expired = (r_idle_cnt == IDLE_CNT_WIDTH'(TIMEOUT_CYCLES - 1));
    assign w_next_ptr     = (r_cur_port == PORT_ID_WIDTH'(N_PORTS - 1)) ? '0 : r_cur_port + 1'b1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_rr_ptr   <= '0;
            r_cur_port <= '0;
            r_beat_cnt <= '0;
            r_idle_cnt <= '0;
            r_gnt      <= '0;
            r_tdata    <= '0;
            r_tvalid   <= 1'b0;
            r_tlast    <= 1'b0;
            r_msg_done <= 1'b0;
            r_timeout  <= 1'b0;
        end else begin
            r_gnt      <= '0;
            r_tvalid   <= 1'b0;
            r_tlast    <= 1'b0;
            r_msg_done <= 1'b0;
            r_timeout  <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (link_ready && w_found) begin
                        r_cur_port <= w_winner;
                        r_gnt      <= N_PORTS'(1) << w_winner;
                        r_beat_cnt <= '0;
                        r_idle_cnt <= '0;
                        r_state    <= S_GRANT;
                    end
                end
                S_GRANT, S_STREAM: begin
                    if (w_valid) begin
                        r_tdata    <= w_data;
                        r_tvalid   <= 1'b1;
                        r_idle_cnt <= '0;
                        if (w_last_beat) begin
                            r_tlast    <= 1'b1;
                            r_msg_done <= 1'b1;
                            r_rr_ptr   <= w_next_ptr;
                            r_state    <= S_GAP;
                        end else begin
                            r_beat_cnt <= r_beat_cnt + 1'b1;
                            r_state    <= S_STREAM;
                        end
                    end else if (r_state == S_GRANT) begin
                        r_state <= S_STREAM;
                    end else if (w_idle_expired) begin
                        // Stalled owner: drop the message without tlast and move on.
                        r_timeout <= 1'b1;
                        r_rr_ptr  <= w_next_ptr;
                        r_state   <= S_GAP;
                    end else begin
                        r_idle_cnt <= r_idle_cnt + 1'b1;
                    end
                end
                S_GAP: begin
                    r_beat_cnt <= '0;
                    r_idle_cnt <= '0;
                    r_state    <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign gnt         = r_gnt;
    assign tx_tdata    = r_tdata;
    assign tx_tvalid   = r_tvalid;
    assign tx_tlast    = r_tlast;
    assign msg_done    = r_msg_done;
    assign timeout_err = r_timeout;
    assign cur_port    = r_cur_port;
    assign busy        = (r_state == S_GRANT) || (r_state == S_STREAM);

`ifdef ENCAP_ARB_STATS_EN
    logic [15:0] r_msg_count;
    logic [7:0]  r_timeout_count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_msg_count     <= '0;
            r_timeout_count <= '0;
        end else begin
            if (r_msg_done) begin
                r_msg_count <= r_msg_count + 1'b1;
            end
            if (r_timeout && (r_timeout_count != 8'hFF)) begin
                r_timeout_count <= r_timeout_count + 1'b1;
            end
        end
    end

    assign msg_count     = r_msg_count;
    assign timeout_count = r_timeout_count;
`endif

endmodule

// File: tb/tb_encap_link_arbiter.sv
// Self-checking bench for encap_link_arbiter: vector table, directed corner sequences,
// and randomized traffic against a message-level reference model.
module tb_encap_link_arbiter;
    localparam int N  = 4;
    localparam int NP = 19;
    localparam int DW = 64;
    localparam int TO = 256;

    logic            clk;
    logic            rst_n;
    logic [N-1:0]    req;
    logic [N-1:0]    gnt;
    logic [N*DW-1:0] data_in;
    logic [N-1:0]    valid_in;
    logic            link_ready;
    logic [DW-1:0]   tx_tdata;
    logic            tx_tvalid;
    logic            tx_tlast;
    logic            busy;
    logic [1:0]      cur_port;
    logic            msg_done;
    logic            timeout_err;
`ifdef ENCAP_ARB_STATS_EN
    logic [15:0]     msg_count;
    logic [7:0]      timeout_count;
`endif

    encap_link_arbiter #(
        .N_PORTS(N), .NUMBER_PACKET(NP), .AURORA_DATA_WIDTH(DW), .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .gnt(gnt), .data_in(data_in),
        .valid_in(valid_in), .link_ready(link_ready), .tx_tdata(tx_tdata),
        .tx_tvalid(tx_tvalid), .tx_tlast(tx_tlast), .busy(busy), .cur_port(cur_port),
        .msg_done(msg_done), .timeout_err(timeout_err)
`ifdef ENCAP_ARB_STATS_EN
        , .msg_count(msg_count), .timeout_count(timeout_count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_mis = 0;

    // Reference model: who owns the lane, how many beats it delivered, how long it has been silent.
    int          m_ptr, m_owner, m_beats, m_silent;
    bit          m_owned, m_first, m_cool;
    logic [N-1:0] e_gnt;
    logic        e_tvalid, e_tlast, e_done, e_to, e_busy;
    logic [DW-1:0] e_tdata;
    int          m_msgc, m_toc;

    typedef struct {
        logic [N-1:0] req;
        logic         link;
        logic [N-1:0] exp_gnt;
        int           exp_cur;
    } vec_t;
    vec_t vecs[8];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_mis++;
            $display("FAIL %s: actual=%0h required=%0h t=%0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_ptr = 0; m_owner = 0; m_beats = 0; m_silent = 0;
        m_owned = 0; m_first = 0; m_cool = 0;
        e_gnt = '0; e_tvalid = 0; e_tlast = 0; e_done = 0; e_to = 0; e_busy = 0;
        e_tdata = '0; m_msgc = 0; m_toc = 0;
    endtask

    task automatic model_step();
        int p;
        if (e_done) m_msgc = (m_msgc + 1) % 65536;
        if (e_to && m_toc < 255) m_toc++;
        e_gnt = '0; e_tvalid = 0; e_tlast = 0; e_done = 0; e_to = 0;
        if (m_cool) begin
            m_cool  = 0;
            m_owned = 0;
        end else if (!m_owned) begin
            if (link_ready) begin
                for (int k = 0; k < N; k++) begin
                    p = (m_ptr + k) % N;
                    if (req[p] && !m_owned) begin
                        m_owned = 1; m_owner = p; m_first = 1; m_beats = 0; m_silent = 0;
                        e_gnt[p] = 1'b1;
                    end
                end
            end
        end else begin
            if (valid_in[m_owner]) begin
                e_tvalid = 1; e_tdata = data_in[m_owner*DW +: DW];
                m_silent = 0; m_beats++;
                if (m_beats == NP) begin
                    e_tlast = 1; e_done = 1; m_ptr = (m_owner + 1) % N; m_cool = 1;
                end
            end else if (!m_first) begin
                m_silent++;
                if (m_silent == TO) begin
                    e_to = 1; m_ptr = (m_owner + 1) % N; m_cool = 1;
                end
            end
            m_first = 0;
        end
        e_busy = m_owned && !m_cool;
    endtask

    task automatic compare_all();
        chk("gnt", 64'(gnt), 64'(e_gnt));
        chk("tvalid", 64'(tx_tvalid), 64'(e_tvalid));
        chk("tlast", 64'(tx_tlast), 64'(e_tlast));
        chk("busy", 64'(busy), 64'(e_busy));
        chk("cur_port", 64'(cur_port), 64'(m_owner));
        chk("msg_done", 64'(msg_done), 64'(e_done));
        chk("timeout_err", 64'(timeout_err), 64'(e_to));
        if (e_tvalid) chk("tdata", tx_tdata, e_tdata);
`ifdef ENCAP_ARB_STATS_EN
        chk("msg_count", 64'(msg_count), 64'(m_msgc));
        chk("timeout_count", 64'(timeout_count), 64'(m_toc));
`endif
    endtask

    // Inputs currently applied are sampled at the coming edge; outputs checked 1 time unit after.
    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
        compare_all();
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        req = '0; valid_in = '0; data_in = '0; link_ready = 1'b0;
        model_reset();
        #1;
        compare_all();
        chk("rst_tdata", tx_tdata, 64'd0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic drive_auto(input bit hold_all, input int p_valid, input int p_link);
        for (int p = 0; p < N; p++) begin
            if (hold_all) req[p] = 1'b1;
            else if (e_gnt[p]) req[p] = 1'b0;
            else if (!req[p] && $urandom_range(0, 99) < 25) req[p] = 1'b1;
            data_in[p*DW +: DW] = {$urandom, $urandom};
        end
        valid_in = 4'($urandom);
        if (m_owned && !m_cool) valid_in[m_owner] = ($urandom_range(0, 99) < p_valid);
        link_ready = ($urandom_range(0, 99) < p_link);
    endtask

    initial begin
        int grants[$];
        int exp_order[5];
        int gap, k;
        bit after_last, seen, tlast_seen;

        vecs[0] = '{4'b0001, 1'b1, 4'b0001, 0};
        vecs[1] = '{4'b0010, 1'b1, 4'b0010, 1};
        vecs[2] = '{4'b1100, 1'b1, 4'b0100, 2};
        vecs[3] = '{4'b1000, 1'b1, 4'b1000, 3};
        vecs[4] = '{4'b1111, 1'b1, 4'b0001, 0};
        vecs[5] = '{4'b0110, 1'b0, 4'b0000, 0};
        vecs[6] = '{4'b0000, 1'b1, 4'b0000, 0};
        vecs[7] = '{4'b1010, 1'b1, 4'b0010, 1};
        exp_order = '{0, 1, 2, 3, 0};

        rst_n = 1'b1; req = '0; valid_in = '0; data_in = '0; link_ready = 1'b0;
        model_reset();
        #2;

        // Arbitration table, each record from a fresh reset (rr pointer at 0)
        for (int i = 0; i < 8; i++) begin
            do_reset();
            req = vecs[i].req; link_ready = vecs[i].link;
            tick();
            chk("tbl_gnt", 64'(gnt), 64'(vecs[i].exp_gnt));
            chk("tbl_cur", 64'(cur_port), 64'(vecs[i].exp_cur));
            chk("tbl_busy", 64'(busy), 64'(vecs[i].exp_gnt != 0));
        end

        // Single requester on port 1
        do_reset();
        req = 4'b0010; link_ready = 1'b1;
        tick();
        chk("single_gnt", 64'(gnt), 64'(4'b0010));
        req = '0;
        for (int i = 0; i < NP; i++) begin
            valid_in = 4'b0010; data_in = '0; data_in[DW +: DW] = 64'(i);
            tick();
            if (i == 0) chk("single_gnt_pulse", 64'(gnt), 64'd0);
            chk("single_data", tx_tdata, 64'(i));
            chk("single_tlast", 64'(tx_tlast), 64'(i == NP - 1));
        end
        chk("single_busy_end", 64'(busy), 64'd0);
        chk("single_done", 64'(msg_done), 64'd1);
        valid_in = '0;
        tick();
        chk("single_gap_tvalid", 64'(tx_tvalid), 64'd0);

        // Round-robin fairness with all requests held and owners streaming back-to-back
        do_reset();
        gap = 0; after_last = 0;
        for (int c = 0; c < 110; c++) begin
            drive_auto(1'b1, 100, 100);
            tick();
            for (int p = 0; p < N; p++) if (gnt[p]) grants.push_back(p);
            if (tx_tvalid && after_last) begin
                chk("rr_gap_min", 64'(gap >= 1), 64'd1);
                after_last = 0;
            end else if (after_last) gap++;
            if (tx_tlast) begin after_last = 1; gap = 0; end
        end
        for (int i = 0; i < 5; i++)
            chk("rr_order", 64'((i < grants.size()) ? grants[i] : 99), 64'(exp_order[i]));

        // Cross-talk: port 0 hammers valid while port 2 owns the lane
        do_reset();
        req = 4'b0100; link_ready = 1'b1;
        tick();
        req = '0;
        for (int i = 0; i < NP; i++) begin
            valid_in = 4'b0101; data_in = '0;
            data_in[0 +: DW] = 64'hDEAD; data_in[2*DW +: DW] = 64'h2000 + 64'(i);
            tick();
            chk("xtalk_data", tx_tdata, 64'h2000 + 64'(i));
            chk("xtalk_tlast", 64'(tx_tlast), 64'(i == NP - 1));
        end
        repeat (3) tick();

        // Watchdog: port 3 stalls after 5 beats, port 0 waits
        do_reset();
        req = 4'b1000; link_ready = 1'b1;
        tick();
        chk("wd_gnt", 64'(gnt), 64'(4'b1000));
        req = 4'b0001;
        for (int i = 0; i < 5; i++) begin
            valid_in = 4'b1000; data_in[3*DW +: DW] = 64'h300 + 64'(i);
            tick();
        end
        valid_in = '0;
        seen = 0; tlast_seen = 0; k = 0;
        while (!seen && k < 400) begin
            tick();
            k++;
            tlast_seen |= tx_tlast;
            if (timeout_err) seen = 1;
        end
        chk("wd_latency", 64'(k), 64'(TO));
        chk("wd_no_tlast", 64'(tlast_seen), 64'd0);
        k = 0;
        while (gnt == '0 && k < 10) begin tick(); k++; end
        chk("wd_next_gnt", 64'(gnt), 64'(4'b0001));

        // Link gating
        do_reset();
        req = 4'b0001; link_ready = 1'b0;
        seen = 0;
        for (int i = 0; i < 50; i++) begin
            tick();
            if (gnt != '0) seen = 1;
        end
        chk("link_no_gnt", 64'(seen), 64'd0);
        link_ready = 1'b1;
        tick();
        chk("link_gnt", 64'(gnt), 64'(4'b0001));

        // Reset in the middle of a message, then a fresh message on port 2
        do_reset();
        req = 4'b0010; link_ready = 1'b1;
        tick();
        req = '0;
        for (int i = 0; i < 8; i++) begin
            valid_in = 4'b0010; data_in[DW +: DW] = 64'h100 + 64'(i);
            tick();
        end
        do_reset();
        chk("midrst_tvalid", 64'(tx_tvalid), 64'd0);
        chk("midrst_busy", 64'(busy), 64'd0);
        req = 4'b0100; link_ready = 1'b1;
        tick();
        chk("midrst_gnt", 64'(gnt), 64'(4'b0100));
        req = '0;
        for (int i = 0; i < NP; i++) begin
            valid_in = 4'b0100; data_in[2*DW +: DW] = 64'(i);
            tick();
            chk("midrst_data", tx_tdata, 64'(i));
            chk("midrst_tlast", 64'(tx_tlast), 64'(i == NP - 1));
        end
        valid_in = '0;
        tick();

        // Randomized traffic against the model
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            drive_auto(1'b0, 85, 90);
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: actual=running required=finished");
        $fatal(1, "bench time limit expired");
    end
endmodule
